time_keeper: RTL

Free-running BCD time-of-day counter that consumes the digit set produced by the time-setting front end and advances it once per second. Sits between the set-time user interface and the display/alarm logic. Accepts a loaded hh:mm value on a level-held load request, acknowledges it, then counts hh:mm:ss with 23:59:59 → 00:00:00 wrap.

---
 rtl/clock_pkg.sv | 30 +++
 rtl/time_keeper_if.sv | 38 +++
 rtl/bcd_digit.sv | 29 ++
 rtl/time_keeper.sv | 79 +++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared time-of-day definitions: BCD digit widths, digit limits and the hh:mm legality rule.
// Both the time setter and the time keeper use these definitions.
package clock_pkg;

    localparam int HL_W = 2;
    localparam int HR_W = 4;
    localparam int ML_W = 3;
    localparam int MR_W = 4;
    localparam int SL_W = 3;
    localparam int SR_W = 4;

    localparam logic [HL_W-1:0] HOURS_TENS_MAX        = 2'd2;
    localparam logic [HR_W-1:0] HOURS_UNITS_MAX       = 4'd9;
    localparam logic [HR_W-1:0] HOURS_UNITS_MAX_AT_20 = 4'd3;
    localparam logic [ML_W-1:0] MIN_SEC_TENS_MAX      = 3'd5;
    localparam logic [MR_W-1:0] UNITS_MAX             = 4'd9;

    // True when the digit set forms a valid 24-hour hh:mm value.
    function automatic logic time_legal(
        input logic [HL_W-1:0] hl,
        input logic [HR_W-1:0] hr,
        input logic [ML_W-1:0] ml,
        input logic [MR_W-1:0] mr
    );
        return (hl <= HOURS_TENS_MAX) && (hr <= HOURS_UNITS_MAX) &&
               ((hl != HOURS_TENS_MAX) || (hr <= HOURS_UNITS_MAX_AT_20)) &&
               (ml <= MIN_SEC_TENS_MAX) && (mr <= UNITS_MAX);
    endfunction

endpackage

// File: rtl/time_keeper_if.sv
// Bundle between the time setter/display side (master) and the time keeper (slave).
// The bundle carries the run/load controls, the hh:mm load digits, and the current time plus event pulses.
interface time_keeper_if;
    import clock_pkg::*;

    logic            run_en;
    logic            load_req;
    logic [HL_W-1:0] i_hours_left;
    logic [HR_W-1:0] i_hours_right;
    logic [ML_W-1:0] i_minutes_left;
    logic [MR_W-1:0] i_minutes_right;

    logic [HL_W-1:0] o_hours_left;
    logic [HR_W-1:0] o_hours_right;
    logic [ML_W-1:0] o_minutes_left;
    logic [MR_W-1:0] o_minutes_right;
    logic [SL_W-1:0] o_seconds_left;
    logic [SR_W-1:0] o_seconds_right;
    logic            load_ack;
    logic            load_err;
    logic            sec_tick;
    logic            day_wrap;

    modport master (
        output run_en, load_req,
               i_hours_left, i_hours_right, i_minutes_left, i_minutes_right,
        input  o_hours_left, o_hours_right, o_minutes_left, o_minutes_right,
               o_seconds_left, o_seconds_right, load_ack, load_err, sec_tick, day_wrap
    );

    modport slave (
        input  run_en, load_req,
               i_hours_left, i_hours_right, i_minutes_left, i_minutes_right,
        output o_hours_left, o_hours_right, o_minutes_left, o_minutes_right,
               o_seconds_left, o_seconds_right, load_ack, load_err, sec_tick, day_wrap
    );

endinterface

// File: rtl/bcd_digit.sv
// Loadable, enabled BCD digit counter that wraps after max_val.
// The carry output is asserted in the cycle the digit wraps, so the next digit can advance on the same edge.
module bcd_digit #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    input  logic [W-1:0] max_val,
    output logic [W-1:0] q,
    output logic         carry
);

    assign carry = en & (q >= max_val);

    // NOTE: state registers use non-blocking assignments so all digits update together on the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= load_val;
        end else if (en) begin
            q <= carry ? '0 : q + W'(1);
        end
    end

endmodule

// File: rtl/time_keeper.sv
// BCD hh:mm:ss time-of-day counter that advances once per TICKS_PER_SEC clocks.
// A rising edge on load_req loads hh:mm; while load_req is held high, the time is frozen.
module time_keeper
    import clock_pkg::*;
#(
    parameter int TICKS_PER_SEC = 50_000_000
) (
    input  logic         clk,
    input  logic         rst,
    time_keeper_if.slave bus
);

    localparam int            PW       = $clog2(TICKS_PER_SEC);
    localparam logic [PW-1:0] PRE_LAST = PW'(TICKS_PER_SEC - 1);

    logic [PW-1:0]   prescaler;
    logic            load_q;
    logic            load_rise;
    logic            legal;
    logic            do_load;
    logic            tick;
    logic [HR_W-1:0] hr_max;
    logic            c_sr, c_sl, c_mr, c_ml, c_hr, c_hl;

    assign load_rise = bus.load_req & ~load_q;
    assign legal     = time_legal(bus.i_hours_left, bus.i_hours_right,
                                  bus.i_minutes_left, bus.i_minutes_right);
    assign do_load   = load_rise & legal;
    // HOLD (load_req high) suppresses the tick, so a load always beats a second boundary.
    assign tick      = ~bus.load_req & bus.run_en & (prescaler == PRE_LAST);
    assign hr_max    = (bus.o_hours_left == HOURS_TENS_MAX) ? HOURS_UNITS_MAX_AT_20 : HOURS_UNITS_MAX;

    always_ff @(posedge clk) begin
        if (rst) begin
            prescaler    <= '0;
            load_q       <= 1'b0;
            bus.load_ack <= 1'b0;
            bus.load_err <= 1'b0;
            bus.sec_tick <= 1'b0;
            bus.day_wrap <= 1'b0;
        end else begin
            load_q       <= bus.load_req;
            bus.load_ack <= do_load;
            bus.load_err <= load_rise & ~legal;
            bus.sec_tick <= tick;
            bus.day_wrap <= c_hl;
            if (do_load || tick) begin
                prescaler <= '0;
            end else if (~bus.load_req && bus.run_en) begin
                prescaler <= prescaler + PW'(1);
            end
        end
    end

    bcd_digit #(.W(SR_W)) u_sec_r (
        .clk(clk), .rst(rst), .load(do_load), .load_val('0), .en(tick),
        .max_val(UNITS_MAX), .q(bus.o_seconds_right), .carry(c_sr));

    bcd_digit #(.W(SL_W)) u_sec_l (
        .clk(clk), .rst(rst), .load(do_load), .load_val('0), .en(c_sr),
        .max_val(MIN_SEC_TENS_MAX), .q(bus.o_seconds_left), .carry(c_sl));

    bcd_digit #(.W(MR_W)) u_min_r (
        .clk(clk), .rst(rst), .load(do_load), .load_val(bus.i_minutes_right), .en(c_sl),
        .max_val(UNITS_MAX), .q(bus.o_minutes_right), .carry(c_mr));

    bcd_digit #(.W(ML_W)) u_min_l (
        .clk(clk), .rst(rst), .load(do_load), .load_val(bus.i_minutes_left), .en(c_mr),
        .max_val(MIN_SEC_TENS_MAX), .q(bus.o_minutes_left), .carry(c_ml));

    bcd_digit #(.W(HR_W)) u_hour_r (
        .clk(clk), .rst(rst), .load(do_load), .load_val(bus.i_hours_right), .en(c_ml),
        .max_val(hr_max), .q(bus.o_hours_right), .carry(c_hr));

    bcd_digit #(.W(HL_W)) u_hour_l (
        .clk(clk), .rst(rst), .load(do_load), .load_val(bus.i_hours_left), .en(c_hr),
        .max_val(HOURS_TENS_MAX), .q(bus.o_hours_left), .carry(c_hl));

endmodule
